// File: rtl/strobe_pulse_gen.sv
// Strobe transmitter: each accepted trigger emits PULSE_LEN high cycles on b_out, then a tail and optional gap.
// Latency: a trigger sampled in IDLE raises b_out right after that edge; b_out and a_out are registered.
// No backpressure: triggers that arrive while busy are queued in pend_cnt; at saturation they are dropped and ovf sticks.
module strobe_pulse_gen #(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              a_in,
    output logic              b_out,
    output logic              a_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    localparam int LEN_W = $clog2(PULSE_LEN + 1);
    localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_TAIL  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [LEN_W-1:0]   len_cnt;
    logic [LEN_W-1:0]   len_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic               b_nxt;
    logic               a_nxt;

    // A decision point is any cycle where a new pulse may legally begin:
    // IDLE, the tail cycle when there is no gap, or the last gap cycle.
    logic decide;
    logic have_pend;
    logic start;
    logic inc;
    logic dec;

    assign decide    = (state == S_IDLE)
                    || ((state == S_TAIL) && (GAP_LEN == 0))
                    || ((state == S_GAP) && (gap_cnt == '0));
    assign have_pend = (pend_cnt != '0);
    assign start     = decide && (trig || have_pend);
    // A queued request is consumed whenever a pulse starts with requests waiting.
    assign dec       = start && have_pend;
    // A trigger that launches a pulse directly (nothing queued) is not counted.
    assign inc       = trig && !(start && !have_pend);
    assign busy      = (state != S_IDLE);

    // State, counters, pending queue and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_cnt  <= '0;
            gap_cnt  <= '0;
            b_out    <= 1'b0;
            a_out    <= 1'b0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state   <= next_state;
            len_cnt <= len_nxt;
            gap_cnt <= gap_nxt;
            b_out   <= b_nxt;
            a_out   <= a_nxt;
            if (inc && !dec) begin
                if (pend_cnt == PEND_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + 1'b1;
                end
            end else if (dec && !inc) begin
                pend_cnt <= pend_cnt - 1'b1;
            end
        end
    end

    // Next-state and pulse/gap length counters; PULSE never re-enters PULSE directly.
    always_comb begin
        next_state = state;
        len_nxt    = len_cnt;
        gap_nxt    = gap_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_PULSE;
                end
            end
            S_PULSE: begin
                if (len_cnt == '0) begin
                    next_state = S_TAIL;
                end else begin
                    len_nxt = len_cnt - 1'b1;
                end
            end
            S_TAIL: begin
                if (GAP_LEN > 0) begin
                    next_state = S_GAP;
                    gap_nxt    = GAP_W'(GAP_LEN - 1);
                end else if (start) begin
                    next_state = S_PULSE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    next_state = start ? S_PULSE : S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (start) begin
            len_nxt = LEN_W'(PULSE_LEN - 1);
        end
    end

    // Outputs are derived from the next state so a_out is already low in the first high cycle of b_out.
    always_comb begin
        b_nxt = (next_state == S_PULSE);
        a_nxt = a_in && !((next_state == S_PULSE) || (next_state == S_TAIL));
    end

endmodule

// File: tb/tb_strobe_pulse_gen.sv
module tb_strobe_pulse_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       trig;
    logic       a_in;
    logic       b_o    [3];
    logic       a_o    [3];
    logic       busy_o [3];
    logic       ovf_o  [3];
    logic [2:0] pend0;
    logic [1:0] pend1;
    logic [2:0] pend2;

    strobe_pulse_gen dut0 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a_in(a_in),
        .b_out(b_o[0]), .a_out(a_o[0]), .busy(busy_o[0]), .pend_cnt(pend0), .ovf(ovf_o[0])
    );

    strobe_pulse_gen #(.PULSE_LEN(2), .GAP_LEN(1), .PEND_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a_in(a_in),
        .b_out(b_o[1]), .a_out(a_o[1]), .busy(busy_o[1]), .pend_cnt(pend1), .ovf(ovf_o[1])
    );

    strobe_pulse_gen #(.PULSE_LEN(1), .GAP_LEN(0), .PEND_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a_in(a_in),
        .b_out(b_o[2]), .a_out(a_o[2]), .busy(busy_o[2]), .pend_cnt(pend2), .ovf(ovf_o[2])
    );

    // Parameters of each instance, as seen by the reference model.
    int PL [3] = '{2, 2, 1};
    int GL [3] = '{1, 1, 0};
    int PW [3] = '{3, 2, 3};

    // Reference model: request count, earliest cycle a new pulse may begin,
    // and the cycle the most recent pulse began. Outputs follow from time windows.
    int m_pend  [3];
    bit m_ovf   [3];
    int m_ready [3];
    int m_start [3];
    bit m_b     [3];
    bit m_a     [3];
    bit m_busy  [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit rst_n;
        bit trig;
        bit a_in;
        bit b;
        bit a;
        bit busy;
        int pend;
        bit ovf;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pend_of(input int k);
        case (k)
            0:       return int'(pend0);
            1:       return int'(pend1);
            default: return int'(pend2);
        endcase
    endfunction

    task automatic model_step(input int k, input bit r, input bit t, input bit ain, input int c);
        int avail;
        int maxp;
        bit forced;
        if (!r) begin
            m_pend[k]  = 0;
            m_ovf[k]   = 1'b0;
            m_ready[k] = 0;
            m_start[k] = -1000;
            m_b[k]     = 1'b0;
            m_a[k]     = 1'b0;
            m_busy[k]  = 1'b0;
            return;
        end
        avail = m_pend[k] + int'(t);
        maxp  = (1 << PW[k]) - 1;
        if (c >= m_ready[k] && avail > 0) begin
            m_start[k] = c;
            m_ready[k] = c + PL[k] + 1 + GL[k];
            m_pend[k]  = avail - 1;
        end else if (avail > maxp) begin
            m_pend[k] = maxp;
            m_ovf[k]  = 1'b1;
        end else begin
            m_pend[k] = avail;
        end
        m_b[k]    = (c >= m_start[k]) && (c < m_start[k] + PL[k]);
        forced    = (c >= m_start[k]) && (c <= m_start[k] + PL[k]);
        m_a[k]    = ain && !forced;
        m_busy[k] = (c < m_ready[k]);
    endtask

    // One clock: inputs already stable, model advances, all instances compared.
    task automatic step();
        bit r;
        bit t;
        bit ai;
        r  = rst_n;
        t  = trig;
        ai = a_in;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            model_step(k, r, t, ai, cyc);
            chk($sformatf("dut%0d_b", k),    int'(b_o[k]),    int'(m_b[k]));
            chk($sformatf("dut%0d_a", k),    int'(a_o[k]),    int'(m_a[k]));
            chk($sformatf("dut%0d_busy", k), int'(busy_o[k]), int'(m_busy[k]));
            chk($sformatf("dut%0d_pend", k), pend_of(k),      m_pend[k]);
            chk($sformatf("dut%0d_ovf", k),  int'(ovf_o[k]),  int'(m_ovf[k]));
        end
        cyc++;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n    = 0;
        trig = 1'b0;
        while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", int'(busy_o[0] || busy_o[1] || busy_o[2]), 0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rises;
        int run;
        int maxrun;
        int n;
        int prob;
        bit prev;

        // Single pulse, then a four-deep burst that queues three requests.
        tbl[0]  = '{1, 1, 1, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 1, 1, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 0, 1, 0, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 1, 1, 0};
        tbl[8]  = '{1, 1, 1, 0, 0, 1, 2, 0};
        tbl[9]  = '{1, 1, 1, 0, 1, 1, 3, 0};
        tbl[10] = '{1, 0, 1, 1, 0, 1, 2, 0};
        tbl[11] = '{1, 0, 1, 1, 0, 1, 2, 0};
        tbl[12] = '{1, 0, 1, 0, 0, 1, 2, 0};
        tbl[13] = '{1, 0, 1, 0, 1, 1, 2, 0};
        tbl[14] = '{1, 0, 1, 1, 0, 1, 1, 0};
        tbl[15] = '{1, 0, 1, 1, 0, 1, 1, 0};
        tbl[16] = '{1, 0, 1, 0, 0, 1, 1, 0};
        tbl[17] = '{1, 0, 1, 0, 1, 1, 1, 0};
        tbl[18] = '{1, 0, 1, 1, 0, 1, 0, 0};
        tbl[19] = '{1, 0, 1, 1, 0, 1, 0, 0};
        tbl[20] = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[21] = '{1, 0, 1, 0, 1, 1, 0, 0};
        tbl[22] = '{1, 0, 1, 0, 1, 0, 0, 0};

        for (int k = 0; k < 3; k++) begin
            m_pend[k]  = 0;
            m_ovf[k]   = 1'b0;
            m_ready[k] = 0;
            m_start[k] = -1000;
            m_b[k]     = 1'b0;
            m_a[k]     = 1'b0;
            m_busy[k]  = 1'b0;
        end

        // Reset state.
        rst_n = 1'b0;
        trig  = 1'b0;
        a_in  = 1'b1;
        step();
        step();
        chk("rst_b",    int'(b_o[0]),    0);
        chk("rst_a",    int'(a_o[0]),    0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_pend", int'(pend0),     0);
        chk("rst_ovf",  int'(ovf_o[0]),  0);

        // Table vectors against the default instance.
        for (int i = 0; i < 23; i++) begin
            rst_n = tbl[i].rst_n;
            trig  = tbl[i].trig;
            a_in  = tbl[i].a_in;
            step();
            chk($sformatf("tbl%0d_b", i),    int'(b_o[0]),    int'(tbl[i].b));
            chk($sformatf("tbl%0d_a", i),    int'(a_o[0]),    int'(tbl[i].a));
            chk($sformatf("tbl%0d_busy", i), int'(busy_o[0]), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_pend", i), int'(pend0),     tbl[i].pend);
            chk($sformatf("tbl%0d_ovf", i),  int'(ovf_o[0]),  int'(tbl[i].ovf));
        end

        // Saturation on the 2-bit queue: 8 trigger cycles, 5 pulses in all.
        wait_idle(100);
        a_in   = 1'b1;
        rises  = 0;
        run    = 0;
        maxrun = 0;
        prev   = 1'b0;
        trig   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b_o[1] && !prev) rises++;
            run    = b_o[1] ? run + 1 : 0;
            maxrun = (run > maxrun) ? run : maxrun;
            prev   = b_o[1];
        end
        chk("sat_pend", int'(pend1),    3);
        chk("sat_ovf",  int'(ovf_o[1]), 1);
        trig = 1'b0;
        n    = 0;
        while (busy_o[1] && n < 60) begin
            step();
            if (b_o[1] && !prev) rises++;
            run    = b_o[1] ? run + 1 : 0;
            maxrun = (run > maxrun) ? run : maxrun;
            prev   = b_o[1];
            n++;
        end
        chk("sat_drained", int'(busy_o[1]), 0);
        chk("sat_pulses",  rises,            5);
        chk("sat_maxrun",  maxrun,           2);
        chk("sat_ovf_sticky", int'(ovf_o[1]), 1);

        // Reset in the first high cycle of b_out.
        wait_idle(100);
        trig = 1'b1;
        step();
        chk("midrst_rise", int'(b_o[0]), 1);
        rst_n = 1'b0;
        trig  = 1'b0;
        step();
        chk("midrst_b",    int'(b_o[0]),    0);
        chk("midrst_a",    int'(a_o[0]),    0);
        chk("midrst_busy", int'(busy_o[0]), 0);
        chk("midrst_pend", int'(pend0),     0);
        chk("midrst_ovf1", int'(ovf_o[1]),  0);
        rst_n = 1'b1;
        a_in  = 1'b1;
        step();
        chk("midrst_notail_b", int'(b_o[0]),    0);
        chk("midrst_notail_a", int'(a_o[0]),    1);
        chk("midrst_idle",     int'(busy_o[0]), 0);

        // a_in toggling through a pulse: blocked over PULSE+TAIL, visible from GAP on.
        wait_idle(100);
        for (int i = 0; i < 6; i++) begin
            trig = (i == 0);
            a_in = i[0];
            step();
            chk($sformatf("atog%0d", i), int'(a_o[0]), (i <= 2) ? 0 : int'(a_in));
        end

        // One-cycle pulses with no gap: alternating 1,0 under a held trigger.
        wait_idle(100);
        trig = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("alt%0d", i), int'(b_o[2]), (i % 2 == 0) ? 1 : 0);
        end
        wait_idle(200);

        // Randomized traffic with bursty trigger density and occasional resets.
        prob = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       prob = 10;
                    1:       prob = 50;
                    default: prob = 90;
                endcase
            end
            rst_n = ($urandom_range(0, 99) != 0);
            trig  = ($urandom_range(0, 99) < prob);
            a_in  = $urandom_range(0, 1);
            step();
        end
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
